// File: rtl/capture_pkg.sv
// Shared types and helpers for the circle capture stage.
// Contents:
//   coord_x_t / coord_y_t : 11-bit x and 10-bit y pixel coordinates
//   point_t               : packed {x, y} corner
//   cap_state_e           : capture FSM states (value 3 is unused)
//   abs_diff              : unsigned |a-b| on x coordinates
//   square_y              : y of corner 2 when the bounding box is forced square
package capture_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 4;

    typedef logic [X_W-1:0] coord_x_t;
    typedef logic [Y_W-1:0] coord_y_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DRAG = 2'd2
    } cap_state_e;

    function automatic coord_x_t abs_diff(input coord_x_t a, input coord_x_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Moves away from ref_y by d in the direction of pen_y, saturating to [0, y_max].
    function automatic coord_y_t square_y(input coord_y_t ref_y, input coord_y_t pen_y,
                                          input coord_x_t d, input coord_y_t y_max);
        logic [X_W:0] sum;
        if (pen_y >= ref_y) begin
            sum = {2'b00, ref_y} + {1'b0, d};
            return (sum > {2'b00, y_max}) ? y_max : sum[Y_W-1:0];
        end
        else begin
            return (d > {1'b0, ref_y}) ? '0 : (ref_y - d[Y_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/frame_counter_sat.sv
// 4-bit saturating frame counter.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : clear; together with i_inc it loads 1 (first qualifying frame)
//   i_inc          : count one frame
//   i_target       : terminal value
//   o_hit          : the next increment reaches i_target (does not depend on i_inc,
//                    so the controller can use it to decide whether to increment)
module frame_counter_sat
    import capture_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;

    assign w_next = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;
    assign o_hit  = (w_next >= i_target);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end
        else if (i_clr) begin
            r_count <= i_inc ? CNT_W'(1) : '0;
        end
        else if (i_inc) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/circle_capture.sv
// Gesture capture: debounces pen-down, anchors corner 1, tracks corner 2 while
// dragging and commits the shape on release. Corners only move on frame ticks.
// Optional feature: define CAPTURE_SQUARE_EN to force a square bounding box
// (corner 2 y follows the x extent).
// Ports:
//   clk_in, rst_in      : pixel clock, synchronous active-low reset
//   new_frame_in        : one-cycle frame tick; pen inputs sampled only then
//   pen_x_in/pen_y_in   : centroid, clamped to H_MAX/V_MAX
//   pen_valid_in        : centroid found this frame
//   pen_down_in         : drawing gesture active
//   clear_in            : drop committed shape (any cycle, beats a tick)
//   x/y_out_1, x/y_out_2: corners (preview in DRAG, committed otherwise)
//   shape_valid_out     : corners are meaningful
//   commit_out          : one-cycle pulse after a committing tick
//   state_out           : FSM state
//
// state | meaning
// IDLE  | waiting for pen down; outputs show committed shape
// ARM   | debouncing pen down, counting qualifying frames
// DRAG  | tracking corner 2; outputs show preview
// (3)   | unused, recovers to IDLE
module circle_capture
    import capture_pkg::*;
#(
    parameter int H_MAX           = 1279,
    parameter int V_MAX           = 719,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int LOST_FRAMES     = 8,
    parameter int MIN_SIZE        = 8
)
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic [10:0] pen_x_in,
    input  logic [9:0]  pen_y_in,
    input  logic        pen_valid_in,
    input  logic        pen_down_in,
    input  logic        clear_in,
    output logic [10:0] x_out_1,
    output logic [9:0]  y_out_1,
    output logic [10:0] x_out_2,
    output logic [9:0]  y_out_2,
    output logic        shape_valid_out,
    output logic        commit_out,
    output logic [1:0]  state_out
);

    localparam coord_x_t X_MAX_C = coord_x_t'(H_MAX);
    localparam coord_y_t Y_MAX_C = coord_y_t'(V_MAX);
    localparam coord_x_t MIN_C   = coord_x_t'(MIN_SIZE);

    cap_state_e r_state, w_state_next;
    point_t     r_anchor, w_anchor_next;
    point_t     r_p1, w_p1_next;
    point_t     r_p2, w_p2_next;
    point_t     r_cmt_p1, w_cmt_p1_next;
    point_t     r_cmt_p2, w_cmt_p2_next;
    logic       r_cmt_valid, w_cmt_valid_next;
    logic       r_commit, w_commit_next;

    point_t     w_pen;
    point_t     w_p2_pen;
    logic       w_tick;
    logic       w_pen_ok;
    logic       w_in_drag;
    logic       w_cnt_clr, w_cnt_inc, w_cnt_hit;
    logic       w_lost_clr, w_lost_inc, w_lost_hit;

    // A clear in a tick cycle discards that tick's sample entirely.
    assign w_tick   = new_frame_in & ~clear_in;
    assign w_pen_ok = pen_down_in & pen_valid_in;

    assign w_pen.x = (pen_x_in > X_MAX_C) ? X_MAX_C : pen_x_in;
    assign w_pen.y = (pen_y_in > Y_MAX_C) ? Y_MAX_C : pen_y_in;

    // Candidate corner 2 from the pen. In ARM corner 1 is about to become the
    // anchor, in DRAG it is the current p1.
    assign w_p2_pen.x = w_pen.x;
`ifdef CAPTURE_SQUARE_EN
    point_t w_ref;
    assign w_ref      = (r_state == DRAG) ? r_p1 : r_anchor;
    assign w_p2_pen.y = square_y(w_ref.y, w_pen.y, abs_diff(w_pen.x, w_ref.x), Y_MAX_C);
`else
    assign w_p2_pen.y = w_pen.y;
`endif

    frame_counter_sat u_cnt (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .i_target (CNT_W'(DEBOUNCE_FRAMES)),
        .o_hit    (w_cnt_hit)
    );

    frame_counter_sat u_lost (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in),
        .i_clr    (w_lost_clr),
        .i_inc    (w_lost_inc),
        .i_target (CNT_W'(LOST_FRAMES)),
        .o_hit    (w_lost_hit)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end
        else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_anchor_next    = r_anchor;
        w_p1_next        = r_p1;
        w_p2_next        = r_p2;
        w_cmt_p1_next    = r_cmt_p1;
        w_cmt_p2_next    = r_cmt_p2;
        w_cmt_valid_next = r_cmt_valid;
        w_commit_next    = 1'b0;
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;
        w_lost_clr       = 1'b0;
        w_lost_inc       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_tick && w_pen_ok) begin
                    w_anchor_next = w_pen;
                    w_cnt_clr     = 1'b1;
                    w_cnt_inc     = 1'b1;
                    if (DEBOUNCE_FRAMES == 1) begin
                        w_p1_next    = w_pen;
                        w_p2_next    = w_pen;
                        w_lost_clr   = 1'b1;
                        w_state_next = DRAG;
                    end
                    else begin
                        w_state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (w_tick) begin
                    if (w_pen_ok) begin
                        w_cnt_inc = 1'b1;
                        if (w_cnt_hit) begin
                            w_p1_next    = r_anchor;
                            w_p2_next    = w_p2_pen;
                            w_lost_clr   = 1'b1;
                            w_state_next = DRAG;
                        end
                    end
                    else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DRAG: begin
                if (w_tick) begin
                    if (w_pen_ok) begin
                        w_p2_next  = w_p2_pen;
                        w_lost_clr = 1'b1;
                    end
                    else if (pen_down_in) begin
                        w_lost_inc = 1'b1;
                        if (w_lost_hit) begin
                            w_state_next = IDLE;
                        end
                    end
                    else begin
                        if (abs_diff(r_p2.x, r_p1.x) >= MIN_C) begin
                            w_cmt_p1_next    = r_p1;
                            w_cmt_p2_next    = r_p2;
                            w_cmt_valid_next = 1'b1;
                            w_commit_next    = 1'b1;
                        end
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (clear_in) begin
            w_state_next     = IDLE;
            w_cmt_p1_next    = '0;
            w_cmt_p2_next    = '0;
            w_cmt_valid_next = 1'b0;
            w_commit_next    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_anchor    <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_cmt_p1    <= '0;
            r_cmt_p2    <= '0;
            r_cmt_valid <= 1'b0;
            r_commit    <= 1'b0;
        end
        else begin
            r_anchor    <= w_anchor_next;
            r_p1        <= w_p1_next;
            r_p2        <= w_p2_next;
            r_cmt_p1    <= w_cmt_p1_next;
            r_cmt_p2    <= w_cmt_p2_next;
            r_cmt_valid <= w_cmt_valid_next;
            r_commit    <= w_commit_next;
        end
    end

    // Pure selection between registers, so outputs only move one cycle after a tick.
    assign w_in_drag       = (r_state == DRAG);
    assign x_out_1         = w_in_drag ? r_p1.x : r_cmt_p1.x;
    assign y_out_1         = w_in_drag ? r_p1.y : r_cmt_p1.y;
    assign x_out_2         = w_in_drag ? r_p2.x : r_cmt_p2.x;
    assign y_out_2         = w_in_drag ? r_p2.y : r_cmt_p2.y;
    assign shape_valid_out = r_cmt_valid | w_in_drag;
    assign commit_out      = r_commit;
    assign state_out       = r_state;

endmodule

// File: doc/circle_capture.md
# circle_capture

Frame-synchronous gesture capture stage that turns a tracked pen centroid into the two corner points consumed by the circle renderer. It debounces pen-down, anchors point 1, tracks point 2 while dragging, and commits the shape on pen release. Output corners change only at frame boundaries so the renderer never tears mid-frame. It sits between the camera centroid tracker and the shape draw stage.

## Interface
- H_MAX, 1279: largest legal x; pen x is clamped to it.
- V_MAX, 719: largest legal y; pen y is clamped to it.
- DEBOUNCE_FRAMES, 3: consecutive qualifying frames needed to arm; legal range 1..15.
- LOST_FRAMES, 8: consecutive invalid-centroid frames in DRAG that abort; legal range 1..15.
- MIN_SIZE, 8: minimum |x2-x1| for a commit.

- clk_in  in  1  pixel clock.
- rst_in  in  1  synchronous, active-low reset.
- new_frame_in  in  1  one-cycle tick at frame start (the frame tick).
- pen_x_in  in  11  centroid x, valid for the current frame.
- pen_y_in  in  10  centroid y.
- pen_valid_in  in  1  centroid found this frame.
- pen_down_in  in  1  drawing gesture active.
- clear_in  in  1  drop the committed shape.
- x_out_1 / y_out_1  out  11/10  corner 1.
- x_out_2 / y_out_2  out  11/10  corner 2.
- shape_valid_out  out  1  corners describe a preview or a committed shape.
- commit_out  out  1  one-cycle pulse on a successful commit.
- state_out  out  2  current FSM state.

## Operation
- Inputs other than clear_in are sampled only in a tick cycle. All other cycles hold state.
- Pen coordinates are clamped to H_MAX/V_MAX before use.
- IDLE (0):
  - On a tick with pen_down&valid: anchor ← pen, cnt ← 1.
  - Go to ARM, or straight to DRAG with p2 ← anchor when DEBOUNCE_FRAMES=1.
- ARM (1), on a tick:
  - If pen_down&valid: cnt++. When cnt reaches DEBOUNCE_FRAMES: p1 ← anchor (the first sample), p2 ← pen, go to DRAG.
  - Otherwise go to IDLE with nothing changed.
- DRAG (2), on a tick:
  - pen_down&valid: p2 ← pen, lost ← 0.
  - pen_down&!valid: lost++. When lost reaches LOST_FRAMES, abort to IDLE.
  - !pen_down: if |p2.x−p1.x| ≥ MIN_SIZE, then committed ← {p1,p2}, committed_valid ← 1, commit_out pulses, go to IDLE. Otherwise reject to IDLE.
- State 3 is unused. An illegal state recovers to IDLE on the next cycle.
- Outputs in DRAG show the preview {p1,p2}. In every other state they show the committed shape.
- shape_valid_out = committed_valid | (state==DRAG).
- On abort or reject, outputs revert to the previous committed shape.
- clear_in, in any cycle:
  - committed_valid ← 0, committed ← 0, state → IDLE.
  - clear_in beats a simultaneous tick; that tick's sample is discarded.
- All arithmetic is unsigned. |a−b| is computed as a≥b ? a−b : b−a, 11 bits.

## Timing
- Reset state:
  - State IDLE; cnt, lost, anchor, p1, p2 and committed all zero; committed_valid 0.
  - Outputs: all corners 0, shape_valid_out 0, commit_out 0, state_out 0.
- A sample taken in tick cycle T appears on the outputs in cycle T+1, registered. Outputs are constant from T+1 until the next tick+1.
- commit_out is high exactly in cycle T+1 of the committing tick.
- clear_in in cycle C takes effect on the outputs at C+1.
- If reset is asserted mid-DRAG, the previous committed shape is lost.
- A tick with pen_down=1 but pen_valid=0 in ARM counts as a failure and returns to IDLE.

## Configuration
- CAPTURE_SQUARE_EN defined:
  - p2.y is replaced by p1.y+d when pen_y ≥ p1.y, otherwise p1.y−d, where d=|p2.x−p1.x|.
  - The result saturates to [0,V_MAX], so the bounding box is square (radius follows x).
- CAPTURE_SQUARE_EN undefined: p2.y is the raw clamped pen_y.

## Structure
- capture_pkg holds:
  - coord_x_t (11b) and coord_y_t (10b) typedefs.
  - point_t struct {x,y}.
  - cap_state_e enum: IDLE=0, ARM=1, DRAG=2.
  - An abs_diff function.
- One sub-module, frame_counter_sat: a 4-bit saturating counter with inc/clr/hit, instantiated for cnt and lost.

## Test plan
- Debounce arm:
  - Ticks 1 and 2 with pen_down=1 at (100,200), then tick 3 with pen_down=0 → state returns to IDLE and shape_valid_out stays 0.
- Drag and commit:
  - Arm at (100,200), drag to (160,260), then release → committed (100,200,160,260).
  - commit_out is high for one cycle, one cycle after the release tick.
- Reject small shape:
  - Commit (100,200,160,260), then drag (300,300)→(305,300) and release → outputs revert to (100,200,160,260), no commit pulse.
- Lost tracking:
  - In DRAG, 8 consecutive ticks with pen_valid=0 → IDLE, outputs revert to the committed shape.
- Clamp and clear:
  - pen_x=2000 during DRAG → x_out_2=1279.
  - clear_in on the same cycle as a tick → IDLE, all corners 0, shape_valid_out 0.
- CAPTURE_SQUARE_EN:
  - p1=(100,700), pen=(150,710) → y_out_2=719 (saturated).
  - Without the macro, y_out_2=710.
